// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage RV32I core plus the EX/MEM pipeline register.
// Redirect (PCSrcE/PCTargetE) is combinational; everything headed to MEM is registered.
module ex_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic [3:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            jalrE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PC4E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [31:0]     InstrE,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            MemWriteM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PC4M,
    output logic [2:0]      Funct3M
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    function automatic logic [XLEN-1:0] alu_fn(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            ALU_ADD:  alu_fn = a + b;
            ALU_SUB:  alu_fn = a - b;
            ALU_AND:  alu_fn = a & b;
            ALU_OR:   alu_fn = a | b;
            ALU_XOR:  alu_fn = a ^ b;
            ALU_SLT:  alu_fn = ($signed(a) < $signed(b)) ? {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}};
            ALU_SLTU: alu_fn = (a < b) ? {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}};
            ALU_SLL:  alu_fn = a << shamt;
            ALU_SRL:  alu_fn = a >> shamt;
            ALU_SRA:  alu_fn = $unsigned($signed(a) >>> shamt);
            default:  alu_fn = {XLEN{1'b0}};
        endcase
    endfunction

    // funct3 010/011 are not branch encodings and must never redirect.
    function automatic logic branch_cond_fn(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        case (f3)
            3'b000:  branch_cond_fn = (a == b);
            3'b001:  branch_cond_fn = (a != b);
            3'b100:  branch_cond_fn = ($signed(a) <  $signed(b));
            3'b101:  branch_cond_fn = ($signed(a) >= $signed(b));
            3'b110:  branch_cond_fn = (a <  b);
            3'b111:  branch_cond_fn = (a >= b);
            default: branch_cond_fn = 1'b0;
        endcase
    endfunction

    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] src_b_s;
    logic [XLEN-1:0] alu_result_s;
    logic            branch_cond_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;

    logic            reg_write_q,   reg_write_d;
    logic [1:0]      result_src_q,  result_src_d;
    logic            mem_write_q,   mem_write_d;
    logic [XLEN-1:0] alu_result_q,  alu_result_d;
    logic [XLEN-1:0] write_data_q,  write_data_d;
    logic [4:0]      rd_q,          rd_d;
    logic [XLEN-1:0] pc4_q,         pc4_d;
    logic [2:0]      funct3_q,      funct3_d;

    // Only opcode and funct3 of the instruction matter here.
    logic unused_instr_s;
    assign unused_instr_s = ^{InstrE[31:15], InstrE[11:7]};

    assign opcode_s = InstrE[6:0];
    assign funct3_s = InstrE[14:12];

    // Forwarding muxes, operand selection, ALU, branch compare and redirect.
    always_comb begin
        case (ForwardAE)
            2'b01:   fwd_a_s = ResultW;
            2'b10:   fwd_a_s = ALUResultM;
            default: fwd_a_s = RD1E;
        endcase

        case (ForwardBE)
            2'b01:   fwd_b_s = ResultW;
            2'b10:   fwd_b_s = ALUResultM;
            default: fwd_b_s = RD2E;
        endcase

        if (opcode_s == OP_LUI) begin
            src_a_s = {XLEN{1'b0}};
        end else if (opcode_s == OP_AUIPC) begin
            src_a_s = PCE;
        end else begin
            src_a_s = fwd_a_s;
        end

        if (ALUSrcE) begin
            src_b_s = ImmExtE;
        end else begin
            src_b_s = fwd_b_s;
        end

        alu_result_s  = alu_fn(ALUControlE, src_a_s, src_b_s);
        branch_cond_s = branch_cond_fn(funct3_s, fwd_a_s, fwd_b_s);
        PCSrcE        = JumpE | jalrE | (BranchE & branch_cond_s);

        if (jalrE) begin
            PCTargetE = (fwd_a_s + ImmExtE) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            PCTargetE = PCE + ImmExtE;
        end
    end

    // Next-state of the EX/MEM register; store data is always forwarded B.
    always_comb begin
        reg_write_d  = RegWriteE;
        result_src_d = ResultSrcE;
        mem_write_d  = MemWriteE;
        alu_result_d = alu_result_s;
        write_data_d = fwd_b_s;
        rd_d         = RdE;
        pc4_d        = PC4E;
        funct3_d     = funct3_s;
    end

    // EX/MEM pipeline register; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            mem_write_q  <= 1'b0;
            alu_result_q <= {XLEN{1'b0}};
            write_data_q <= {XLEN{1'b0}};
            rd_q         <= 5'd0;
            pc4_q        <= {XLEN{1'b0}};
            funct3_q     <= 3'b000;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            pc4_q        <= pc4_d;
            funct3_q     <= funct3_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign ResultSrcM = result_src_q;
    assign MemWriteM  = mem_write_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign RdM        = rd_q;
    assign PC4M       = pc4_q;
    assign Funct3M    = funct3_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage: redirect checked combinationally,
// EX/MEM outputs checked one cycle after the inputs are applied.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE;
    logic        JumpE;
    logic        BranchE;
    logic        jalrE;
    logic [31:0] RD1E, RD2E, PCE, PC4E, ImmExtE, InstrE, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PC4M;
    logic [4:0]  RdM;
    logic [2:0]  Funct3M;

    int total_cnt = 0;
    int bad_cnt   = 0;

    ex_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .JumpE(JumpE), .BranchE(BranchE), .jalrE(jalrE), .RD1E(RD1E), .RD2E(RD2E),
        .PCE(PCE), .PC4E(PC4E), .ImmExtE(ImmExtE), .InstrE(InstrE), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .PC4M(PC4M), .Funct3M(Funct3M)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        RegWriteE = 1'b0; ResultSrcE = 2'b00; MemWriteE = 1'b0; ALUControlE = 4'b0000;
        ALUSrcE = 1'b0; JumpE = 1'b0; BranchE = 1'b0; jalrE = 1'b0;
        RD1E = 32'h0; RD2E = 32'h0; PCE = 32'h0; PC4E = 32'h0; ImmExtE = 32'h0;
        InstrE = 32'h0; RdE = 5'd0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'h0;
    endtask

    // Sets up an ALU op on RD1E/second operand (imm when use_imm) with R-type opcode.
    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic use_imm);
        drive_idle();
        InstrE      = 32'h0000_0033;
        ALUControlE = op;
        RD1E        = a;
        ALUSrcE     = use_imm;
        if (use_imm) ImmExtE = b;
        else         RD2E    = b;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        drive_idle();
        BranchE = 1'b1;
        InstrE  = {17'h0, f3, 5'h0, 7'b1100011};
        RD1E    = a;
        RD2E    = b;
        PCE     = 32'h40;
        ImmExtE = 32'hFFFF_FFF8;
    endtask

    initial begin
        // Reset with random inputs; JumpE forced so the redirect is visible.
        reset = 1'b1;
        RegWriteE = 1'b1; ResultSrcE = 2'($urandom_range(0, 3)); MemWriteE = 1'b1;
        ALUControlE = 4'($urandom_range(0, 15)); ALUSrcE = 1'($urandom_range(0, 1));
        JumpE = 1'b1; BranchE = 1'($urandom_range(0, 1)); jalrE = 1'b0;
        RD1E = $urandom; RD2E = $urandom; PCE = 32'h0000_1000; PC4E = $urandom | 32'h1;
        ImmExtE = 32'h0000_0010; InstrE = $urandom; RdE = 5'd31;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = $urandom;
        cycle();
        cycle();
        check_eq("rst_regwrite",  32'(RegWriteM),  32'h0);
        check_eq("rst_resultsrc", 32'(ResultSrcM), 32'h0);
        check_eq("rst_memwrite",  32'(MemWriteM),  32'h0);
        check_eq("rst_aluresult", ALUResultM,      32'h0);
        check_eq("rst_writedata", WriteDataM,      32'h0);
        check_eq("rst_rd",        32'(RdM),        32'h0);
        check_eq("rst_pc4",       PC4M,            32'h0);
        check_eq("rst_funct3",    32'(Funct3M),    32'h0);
        check_eq("rst_pcsrc",     32'(PCSrcE),     32'h1);
        check_eq("rst_pctarget",  PCTargetE,       32'h0000_1010);

        // ADD 5+7 into x3.
        reset = 1'b0;
        drive_alu(4'b0000, 32'd5, 32'd7, 1'b0);
        RegWriteE = 1'b1; RdE = 5'd3;
        #1 check_eq("add_pcsrc", 32'(PCSrcE), 32'h0);
        cycle();
        check_eq("add_result", ALUResultM, 32'd12);
        check_eq("add_rd",     32'(RdM), 32'd3);
        check_eq("add_regwr",  32'(RegWriteM), 32'h1);

        // Produce 0x100, then SUB with A forwarded from ALUResultM.
        drive_alu(4'b0000, 32'h80, 32'h80, 1'b0);
        cycle();
        check_eq("fwd_seed", ALUResultM, 32'h100);
        drive_alu(4'b0001, 32'h55, 32'd1, 1'b0);
        ForwardAE = 2'b10;
        cycle();
        check_eq("fwdA_sub", ALUResultM, 32'hFF);

        // Store: B forwarded from ResultW, imm addressing, A code 11 -> RD1E.
        drive_idle();
        InstrE = {17'h0, 3'b010, 5'h0, 7'b0100011};
        MemWriteE = 1'b1; ALUSrcE = 1'b1; ImmExtE = 32'd4; RD1E = 32'h200;
        RD2E = 32'hDEAD; ForwardAE = 2'b11; ForwardBE = 2'b01; ResultW = 32'd9;
        cycle();
        check_eq("st_wdata",  WriteDataM, 32'd9);
        check_eq("st_addr",   ALUResultM, 32'h204);
        check_eq("st_memwr",  32'(MemWriteM), 32'h1);
        check_eq("st_funct3", 32'(Funct3M), 32'h2);
        check_eq("st_regwr",  32'(RegWriteM), 32'h0);

        // Branches: PCE=0x40, imm=-8.
        drive_branch(3'b000, 32'h1234, 32'h1234);
        #1 check_eq("beq_taken", 32'(PCSrcE), 32'h1);
        check_eq("beq_target", PCTargetE, 32'h38);
        drive_branch(3'b001, 32'h1234, 32'h1234);
        #1 check_eq("bne_not", 32'(PCSrcE), 32'h0);
        drive_branch(3'b110, 32'h1, 32'hFFFF_FFFF);
        #1 check_eq("bltu_taken", 32'(PCSrcE), 32'h1);
        drive_branch(3'b100, 32'h1, 32'hFFFF_FFFF);
        #1 check_eq("blt_not", 32'(PCSrcE), 32'h0);
        drive_branch(3'b101, 32'h1, 32'hFFFF_FFFF);
        #1 check_eq("bge_taken", 32'(PCSrcE), 32'h1);
        drive_branch(3'b111, 32'h1, 32'hFFFF_FFFF);
        #1 check_eq("bgeu_not", 32'(PCSrcE), 32'h0);
        drive_branch(3'b010, 32'h5, 32'h5);
        #1 check_eq("f3_010_not", 32'(PCSrcE), 32'h0);

        // JALR target clears bit 0; PC+4 carried to MEM.
        drive_idle();
        jalrE = 1'b1; RD1E = 32'h1001; ImmExtE = 32'd2; ResultSrcE = 2'b10;
        PCE = 32'h500; PC4E = 32'h504; RegWriteE = 1'b1; RdE = 5'd1;
        #1 check_eq("jalr_pcsrc", 32'(PCSrcE), 32'h1);
        check_eq("jalr_target", PCTargetE, 32'h1002);
        cycle();
        check_eq("jalr_pc4",    PC4M, 32'h504);
        check_eq("jalr_rsrc",   32'(ResultSrcM), 32'h2);

        // ALU op sweep.
        drive_alu(4'b1001, 32'h8000_0000, 32'h24, 1'b1);
        cycle(); check_eq("sra", ALUResultM, 32'hF800_0000);
        drive_alu(4'b1000, 32'h8000_0000, 32'h24, 1'b1);
        cycle(); check_eq("srl", ALUResultM, 32'h0800_0000);
        drive_alu(4'b0111, 32'h1, 32'h24, 1'b0);
        cycle(); check_eq("sll", ALUResultM, 32'h10);
        drive_alu(4'b0101, 32'hFFFF_FFFF, 32'h1, 1'b0);
        cycle(); check_eq("slt", ALUResultM, 32'h1);
        drive_alu(4'b0110, 32'hFFFF_FFFF, 32'h1, 1'b0);
        cycle(); check_eq("sltu", ALUResultM, 32'h0);
        drive_alu(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        cycle(); check_eq("xor", ALUResultM, 32'h0FF0_0FF0);
        drive_alu(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        cycle(); check_eq("and", ALUResultM, 32'hF000_F000);
        drive_alu(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        cycle(); check_eq("or", ALUResultM, 32'hFFF0_FFF0);
        drive_alu(4'b0001, 32'h0, 32'h1, 1'b0);
        cycle(); check_eq("sub_wrap", ALUResultM, 32'hFFFF_FFFF);
        drive_alu(4'b1100, 32'h1234, 32'h5678, 1'b0);
        cycle(); check_eq("op_1100", ALUResultM, 32'h0);

        // AUIPC / LUI.
        drive_alu(4'b0000, 32'h5555, 32'h2000, 1'b1);
        InstrE = 32'h0000_0017; PCE = 32'h1000;
        cycle(); check_eq("auipc", ALUResultM, 32'h3000);
        drive_alu(4'b0000, 32'h5555, 32'hABCD_E000, 1'b1);
        InstrE = 32'h0000_0037;
        cycle(); check_eq("lui", ALUResultM, 32'hABCD_E000);

        // Bubble passes through.
        drive_idle();
        #1 check_eq("bub_pcsrc", 32'(PCSrcE), 32'h0);
        cycle();
        check_eq("bub_regwr", 32'(RegWriteM), 32'h0);
        check_eq("bub_memwr", 32'(MemWriteM), 32'h0);

        // Reset mid-stream beats capture.
        drive_alu(4'b0000, 32'h10, 32'h20, 1'b0);
        RegWriteE = 1'b1; RdE = 5'd7; reset = 1'b1;
        cycle();
        check_eq("rst2_result", ALUResultM, 32'h0);
        check_eq("rst2_rd", 32'(RdM), 32'h0);
        reset = 1'b0;
        cycle();
        check_eq("post_rst_result", ALUResultM, 32'h30);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
